serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor computing diff = a - b - bor_in, LSB first.

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Brief    : start/busy/done handshake and operand/result bus of the
//             bit-serial subtractor.
//  Revision : 1.0
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bor_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bor_out;

    modport master (
        output start, a_in, b_in, bor_in,
        input  busy, done, diff, bor_out
    );

    modport slave (
        input  start, a_in, b_in, bor_in,
        output busy, done, diff, bor_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Bit-serial unsigned subtractor, diff = a - b - bor_in, LSB first,
//             one full-subtractor step per clock.
//  Revision : 1.0
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam int         c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res;
    logic               r_brw;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bor;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_a0;
    logic               w_b0;
    logic               w_d;
    logic               w_brw_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_next = c_SHIFT;
            c_SHIFT: if (r_cnt == c_LAST) w_state_next = c_DONE;
            c_DONE:  w_state_next = bus.start ? c_SHIFT : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Control decode; start is only honoured outside SHIFT
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            c_IDLE:  w_load = bus.start;
            c_SHIFT: begin
                w_step = 1'b1;
                w_last = (r_cnt == c_LAST);
            end
            c_DONE:  w_load = bus.start;
            default: ;
        endcase
    end

    assign w_a0       = r_a_sr[0];
    assign w_b0       = r_b_sr[0];
    assign w_d        = w_a0 ^ w_b0 ^ r_brw;
    assign w_brw_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_brw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_res  <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_diff <= '0;
            r_bor  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == c_SHIFT);
            r_done <= w_last;
            if (w_load) begin
                r_a_sr <= bus.a_in;
                r_b_sr <= bus.b_in;
                r_brw  <= bus.bor_in;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                r_res  <= {w_d, r_res[WIDTH-1:1]};
                r_brw  <= w_brw_next;
                r_cnt  <= r_cnt + c_CNT_W'(1);
                // Results are published only on the final step
                if (w_last) begin
                    r_diff <= {w_d, r_res[WIDTH-1:1]};
                    r_bor  <= w_brw_next;
                end
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.diff    = r_diff;
    assign bus.bor_out = r_bor;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8 and
//             an exhaustive WIDTH=3 instance).
//  Revision : 1.0
// ============================================================================
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(3)) bus3 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start on the 8-bit unit and returns at the negedge where done
    // is seen; lat counts cycles after the start edge (-1 on timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input bit b2b, output int lat, output int bcnt);
        if (!b2b) @(negedge clk);
        bus8.a_in = a; bus8.b_in = b; bus8.bor_in = bi; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a_in = ~a; bus8.b_in = ~b; bus8.bor_in = ~bi;
        lat = -1; bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus8.busy) bcnt++;
            @(negedge clk);
            if (bus8.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks += 4;
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus8.busy); end
        if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus8.done); end
        if (bus8.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", bus8.diff); end
        if (bus8.bor_out !== 1'b0) begin n_fail++; $display("FAIL reset_bor got %b want 0", bus8.bor_out); end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run8(8'h35, 8'h12, 1'b0, 1'b0, lat, bcnt);
        n_checks += 5;
        if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
        if (bcnt !== 8) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
        if (bus8.diff !== 8'h23) begin n_fail++; $display("FAIL basic_diff got %h want 23", bus8.diff); end
        if (bus8.bor_out !== 1'b0) begin n_fail++; $display("FAIL basic_bor got %b want 0", bus8.bor_out); end
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done got %b want 0", bus8.busy); end
        @(negedge clk);
        n_checks++;
        if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", bus8.done); end
    endtask

    task automatic test_hold();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.diff !== 8'h23 || bus8.bor_out !== 1'b0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0)
                bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable got diff=%h bor=%b busy=%b done=%b want 23/0/0/0",
                     bus8.diff, bus8.bor_out, bus8.busy, bus8.done);
        end
    endtask

    task automatic test_wrap();
        int lat, bcnt;
        run8(8'h00, 8'h01, 1'b0, 1'b0, lat, bcnt);
        n_checks += 3;
        if (lat !== 8) begin n_fail++; $display("FAIL wrap1_latency got %0d want 8", lat); end
        if (bus8.diff !== 8'hFF) begin n_fail++; $display("FAIL wrap1_diff got %h want ff", bus8.diff); end
        if (bus8.bor_out !== 1'b1) begin n_fail++; $display("FAIL wrap1_bor got %b want 1", bus8.bor_out); end
        run8(8'h80, 8'h7F, 1'b1, 1'b0, lat, bcnt);
        n_checks += 2;
        if (bus8.diff !== 8'h00) begin n_fail++; $display("FAIL wrap2_diff got %h want 00", bus8.diff); end
        if (bus8.bor_out !== 1'b0) begin n_fail++; $display("FAIL wrap2_bor got %b want 0", bus8.bor_out); end
    endtask

    task automatic test_ignore_and_back_to_back();
        int lat, bcnt;
        @(negedge clk);
        bus8.a_in = 8'h10; bus8.b_in = 8'h01; bus8.bor_in = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.start = 1'b1;
            end
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.done) begin
                lat = i;
                break;
            end
        end
        n_checks += 3;
        if (lat !== 8) begin n_fail++; $display("FAIL ignore_latency got %0d want 8", lat); end
        if (bus8.diff !== 8'h0F) begin n_fail++; $display("FAIL ignore_diff got %h want 0f", bus8.diff); end
        if (bus8.bor_out !== 1'b0) begin n_fail++; $display("FAIL ignore_bor got %b want 0", bus8.bor_out); end
        // New start presented in the DONE cycle
        run8(8'h05, 8'h07, 1'b0, 1'b1, lat, bcnt);
        n_checks += 3;
        if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
        if (bus8.diff !== 8'hFE) begin n_fail++; $display("FAIL b2b_diff got %h want fe", bus8.diff); end
        if (bus8.bor_out !== 1'b1) begin n_fail++; $display("FAIL b2b_bor got %b want 1", bus8.bor_out); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic saw_done;
        @(negedge clk);
        bus8.a_in = 8'hA0; bus8.b_in = 8'h30; bus8.bor_in = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus8.busy); end
        if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", bus8.done); end
        if (bus8.diff !== 8'h00) begin n_fail++; $display("FAIL midrst_diff got %h want 00", bus8.diff); end
        if (bus8.bor_out !== 1'b0) begin n_fail++; $display("FAIL midrst_bor got %b want 0", bus8.bor_out); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
        run8(8'h64, 8'h0A, 1'b1, 1'b0, lat, bcnt);
        n_checks += 3;
        if (lat !== 8) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 8", lat); end
        if (bus8.diff !== 8'h59) begin n_fail++; $display("FAIL midrst_next_diff got %h want 59", bus8.diff); end
        if (bus8.bor_out !== 1'b0) begin n_fail++; $display("FAIL midrst_next_bor got %b want 0", bus8.bor_out); end
    endtask

    task automatic test_exhaustive_w3();
        logic [3:0] exp;
        int lat;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    exp = 4'(a - b - c);
                    @(negedge clk);
                    bus3.a_in = 3'(a); bus3.b_in = 3'(b); bus3.bor_in = c[0]; bus3.start = 1'b1;
                    @(negedge clk);
                    bus3.start = 1'b0;
                    lat = -1;
                    for (int i = 1; i <= 10; i++) begin
                        @(negedge clk);
                        if (bus3.done) begin
                            lat = i;
                            break;
                        end
                    end
                    n_checks += 2;
                    if (lat !== 3) begin
                        n_fail++;
                        $display("FAIL w3_latency a=%0d b=%0d c=%0d got %0d want 3", a, b, c, lat);
                    end
                    if ({bus3.bor_out, bus3.diff} !== exp) begin
                        n_fail++;
                        $display("FAIL w3_result a=%0d b=%0d c=%0d got %h want %h",
                                 a, b, c, {bus3.bor_out, bus3.diff}, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.bor_in = 1'b0;
        bus3.start = 1'b0; bus3.a_in = '0; bus3.b_in = '0; bus3.bor_in = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_hold();
        test_wrap();
        test_ignore_and_back_to_back();
        test_reset_mid();
        test_exhaustive_w3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
